// File: rtl/int_vect_ctrl_pkg.sv
// int_vect_ctrl_pkg
// Shared definitions for the vectored interrupt controller slice:
// - layout of one VICVectCntl slot field (enable bit, source field)
// - address width of vector/default ISR addresses
// - helper for the width of the slot-select index (slots, default, NONE)
package int_vect_ctrl_pkg;

  // One VectCntl slot: bit 5 = enable, bits 4:0 = IRQ source number
  localparam int SLOT_W       = 6;
  localparam int CNTL_EN_BIT  = 5;
  localparam int CNTL_SRC_LSB = 0;

  localparam int ADDR_W = 32;

  // Index must represent slots 0..NUM_VECT-1, the default level NUM_VECT,
  // the "mask empty" level NUM_VECT+1 and leave an all-ones NONE code free
  // for the registered selection.
  function automatic int sel_width(input int num_vect);
    return $clog2(num_vect + 2);
  endfunction

endpackage

// File: rtl/int_vect_prio_enc.sv
// int_vect_prio_enc
// Combinational lowest-index priority encoder.
// Ports:
//   vec   : request vector, bit 0 has the highest priority
//   idx   : index of the lowest set bit (0 when none)
//   valid : at least one bit of vec is set
module int_vect_prio_enc #(
  parameter int W  = 17,
  parameter int IW = 5
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_vect_ctrl.sv
// int_vect_ctrl
// Vectored-priority stage behind the interrupt generator. Maps IRQ sources
// onto NUM_VECT prioritised slots (slot 0 highest, default level lowest),
// drives registered nVICIRQ/nVICFIQ and the vector address, and tracks an
// in-service mask so only strictly higher priorities pre-empt.
// Optional build macro: VIC_DAISY_CHAIN_EN (adds nVICIRQIN/VICVECTADDRIN
// from a chained controller, used when nothing local is eligible).
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   IRQStatus, FIQStatus      : enabled IRQ/FIQ requests
//   top_reg_VICVectCntl       : per-slot {enable, source} fields, 6 bits each
//   top_reg_VICVectAddr       : per-slot ISR address, 32 bits each
//   top_reg_VICDefVectAddr    : default (non-vectored) ISR address
//   vectaddr_rd / vectaddr_wr : bus read (ISR entry) / write (end of service)
//   intvect_reg_VICVectAddr   : registered vector address
//   nVICIRQ / nVICFIQ         : registered active-low requests to the core
//   intvect_isr_mask          : in-service mask, bit NUM_VECT = default level
module int_vect_ctrl
  import int_vect_ctrl_pkg::*;
#(
  parameter int NUM_VECT = 16,
  parameter int PW       = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  IRQStatus,
  input  logic [31:0]                  FIQStatus,
  input  logic [NUM_VECT*SLOT_W-1:0]   top_reg_VICVectCntl,
  input  logic [NUM_VECT*ADDR_W-1:0]   top_reg_VICVectAddr,
  input  logic [ADDR_W-1:0]            top_reg_VICDefVectAddr,
  input  logic                         vectaddr_rd,
  input  logic                         vectaddr_wr,
`ifdef VIC_DAISY_CHAIN_EN
  input  logic                         nVICIRQIN,
  input  logic [ADDR_W-1:0]            VICVECTADDRIN,
`endif
  output logic [ADDR_W-1:0]            intvect_reg_VICVectAddr,
  output logic                         nVICIRQ,
  output logic                         nVICFIQ,
  output logic [NUM_VECT:0]            intvect_isr_mask
);

  localparam int MW = NUM_VECT + 1;
  localparam int SW = sel_width(NUM_VECT);
  localparam logic [SW-1:0] SEL_NONE = '1;

  logic [MW-1:0]     isr_mask_reg, isr_mask_next;
  logic [SW-1:0]     sel_reg, sel_next;
  logic              nvicirq_reg, nvicirq_next;
  logic              nvicfiq_reg;
  logic [ADDR_W-1:0] addr_reg, addr_next;

  logic [NUM_VECT-1:0] req;
  logic [ADDR_W-1:0]   slot_addr [NUM_VECT];
  logic                dreq;
  logic [MW-1:0]       elig;
  logic [SW-1:0]       cur_idx, sel_idx;
  logic                cur_valid, sel_valid;

  // Per-slot request decode and address unpacking
  for (genvar gi = 0; gi < NUM_VECT; gi++) begin : g_slot
    logic          slot_en;
    logic [PW-1:0] slot_src;
    assign slot_en       = top_reg_VICVectCntl[gi*SLOT_W + CNTL_EN_BIT];
    assign slot_src      = top_reg_VICVectCntl[gi*SLOT_W + CNTL_SRC_LSB +: PW];
    assign req[gi]       = slot_en & IRQStatus[slot_src];
    assign slot_addr[gi] = top_reg_VICVectAddr[gi*ADDR_W +: ADDR_W];
  end

  // Default level only requests when no vectored slot claims anything.
  assign dreq = (|IRQStatus) & ~(|req);

  // Current in-service level; invalid means mask empty (level NUM_VECT+1).
  int_vect_prio_enc #(.W(MW), .IW(SW)) u_cur_enc (
    .vec   (isr_mask_reg),
    .idx   (cur_idx),
    .valid (cur_valid)
  );

  // Only strictly higher priority than the current level may pre-empt.
  for (genvar gi = 0; gi < NUM_VECT; gi++) begin : g_elig
    assign elig[gi] = req[gi] & (~cur_valid | (SW'(gi) < cur_idx));
  end
  assign elig[NUM_VECT] = dreq & ~cur_valid;

  int_vect_prio_enc #(.W(MW), .IW(SW)) u_sel_enc (
    .vec   (elig),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  always_comb begin
    nvicirq_next = ~sel_valid;
    sel_next     = sel_valid ? sel_idx : SEL_NONE;
    addr_next    = top_reg_VICDefVectAddr;
    for (int i = 0; i < NUM_VECT; i++) begin
      if (sel_valid && sel_idx == SW'(i)) begin
        addr_next = slot_addr[i];
      end
    end
`ifdef VIC_DAISY_CHAIN_EN
    if (!sel_valid) begin
      nvicirq_next = nVICIRQIN;
      addr_next    = VICVECTADDRIN;
    end
`endif
  end

  // In-service mask update. A read only claims a level when the core was
  // actually being interrupted by a local selection; a write retires the
  // lowest (highest-priority) in-service level, a no-op on an empty mask.
  logic          rd_valid, wr_valid;
  logic [MW-1:0] low_bit, set_bit;

  assign rd_valid = vectaddr_rd & ~nvicirq_reg & (sel_reg != SEL_NONE);
`ifdef VIC_DAISY_CHAIN_EN
  // While the chained controller owns the interrupt, bus accesses are its own.
  assign wr_valid = vectaddr_wr & ~((sel_reg == SEL_NONE) & ~nvicirq_reg);
`else
  assign wr_valid = vectaddr_wr;
`endif
  assign low_bit  = isr_mask_reg & (~isr_mask_reg + MW'(1));
  assign set_bit  = rd_valid ? (MW'(1) << sel_reg) : '0;

  always_comb begin
    isr_mask_next = (isr_mask_reg & ~(wr_valid ? low_bit : '0)) | set_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isr_mask_reg <= '0;
      sel_reg      <= SEL_NONE;
      nvicirq_reg  <= 1'b1;
      nvicfiq_reg  <= 1'b1;
      addr_reg     <= '0;
    end else begin
      isr_mask_reg <= isr_mask_next;
      sel_reg      <= sel_next;
      nvicirq_reg  <= nvicirq_next;
      nvicfiq_reg  <= ~(|FIQStatus);
      addr_reg     <= addr_next;
    end
  end

  assign intvect_reg_VICVectAddr = addr_reg;
  assign nVICIRQ                 = nvicirq_reg;
  assign nVICFIQ                 = nvicfiq_reg;
  assign intvect_isr_mask        = isr_mask_reg;

endmodule

// File: tb/tb_int_vect_ctrl.sv
// Testbench for int_vect_ctrl: table of per-cycle inputs with expected
// registered outputs, plus hand-written reset sequences.
module tb_int_vect_ctrl;

  localparam int NV = 16;
  localparam logic [31:0] DEF = 32'h0000_DEF0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       IRQStatus = '0;
  logic [31:0]       FIQStatus = '0;
  logic [NV*6-1:0]   vect_cntl = '0;
  logic [NV*32-1:0]  vect_addr = '0;
  logic              vectaddr_rd = 1'b0;
  logic              vectaddr_wr = 1'b0;
  logic [31:0]       vaddr;
  logic              nirq, nfiq;
  logic [NV:0]       mask;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  int_vect_ctrl #(.NUM_VECT(NV), .PW(5)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .IRQStatus              (IRQStatus),
    .FIQStatus              (FIQStatus),
    .top_reg_VICVectCntl    (vect_cntl),
    .top_reg_VICVectAddr    (vect_addr),
    .top_reg_VICDefVectAddr (DEF),
    .vectaddr_rd            (vectaddr_rd),
    .vectaddr_wr            (vectaddr_wr),
`ifdef VIC_DAISY_CHAIN_EN
    .nVICIRQIN              (1'b1),
    .VICVECTADDRIN          (DEF),
`endif
    .intvect_reg_VICVectAddr(vaddr),
    .nVICIRQ                (nirq),
    .nVICFIQ                (nfiq),
    .intvect_isr_mask       (mask)
  );

  typedef struct {
    logic [31:0] irq;
    logic [31:0] fiq;
    logic        rd;
    logic        wr;
    logic        exp_nirq;
    logic        exp_nfiq;
    logic [31:0] exp_addr;
    logic [31:0] exp_mask;
  } vec_t;

  localparam int NROWS = 34;
  vec_t tbl [NROWS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic en, input logic ef,
                         input logic [31:0] ea, input logic [31:0] em);
    chk({tag, ".nVICIRQ"}, {31'd0, nirq}, {31'd0, en});
    chk({tag, ".nVICFIQ"}, {31'd0, nfiq}, {31'd0, ef});
    chk({tag, ".vectaddr"}, vaddr, ea);
    chk({tag, ".isr_mask"}, {15'd0, mask}, em);
  endtask

  initial begin
    // Slot configuration: {enable, src}, per-slot addresses
    vect_cntl[0*6 +: 6] = {1'b1, 5'd3};
    vect_cntl[1*6 +: 6] = {1'b1, 5'd9};
    vect_cntl[2*6 +: 6] = {1'b1, 5'd7};
    vect_cntl[3*6 +: 6] = {1'b1, 5'd11};
    vect_cntl[5*6 +: 6] = {1'b1, 5'd20};
    for (int i = 0; i < NV; i++) vect_addr[i*32 +: 32] = 32'h1000 + 32'(i) * 32'h10;
    vect_addr[0*32 +: 32] = 32'h100;
    vect_addr[1*32 +: 32] = 32'h200;
    vect_addr[2*32 +: 32] = 32'h300;
    vect_addr[3*32 +: 32] = 32'h400;
    vect_addr[5*32 +: 32] = 32'h600;

    //           irq          fiq rd wr nirq nfiq addr      mask
    tbl[0]  = '{32'h8,        0, 0, 0, 0, 1, 32'h100, 32'h0};      // slot0 requests
    tbl[1]  = '{32'h8,        0, 1, 0, 0, 1, 32'h100, 32'h1};      // rd claims slot0
    tbl[2]  = '{32'h8,        0, 0, 0, 1, 1, DEF,     32'h1};      // masked
    tbl[3]  = '{32'h88,       0, 0, 0, 1, 1, DEF,     32'h1};      // slot2 lower prio
    tbl[4]  = '{32'h80,       0, 0, 1, 1, 1, DEF,     32'h0};      // wr retires slot0
    tbl[5]  = '{32'h80,       0, 0, 0, 0, 1, 32'h300, 32'h0};      // slot2 now wins
    tbl[6]  = '{32'h80,       0, 1, 0, 0, 1, 32'h300, 32'h4};      // claim slot2
    tbl[7]  = '{32'h88,       0, 0, 0, 0, 1, 32'h100, 32'h4};      // slot0 pre-empts
    tbl[8]  = '{32'h88,       0, 1, 1, 0, 1, 32'h100, 32'h1};      // rd+wr same cycle
    tbl[9]  = '{32'h88,       0, 0, 0, 1, 1, DEF,     32'h1};
    tbl[10] = '{32'h0,        0, 0, 1, 1, 1, DEF,     32'h0};
    tbl[11] = '{32'h0,        0, 0, 1, 1, 1, DEF,     32'h0};      // wr on empty mask
    tbl[12] = '{32'h800,      0, 0, 0, 0, 1, 32'h400, 32'h0};      // slot3
    tbl[13] = '{32'h800,      0, 1, 0, 0, 1, 32'h400, 32'h8};
    tbl[14] = '{32'h800,      0, 0, 0, 1, 1, DEF,     32'h8};
    tbl[15] = '{32'hA00,      0, 0, 0, 0, 1, 32'h200, 32'h8};      // slot1 pre-empts
    tbl[16] = '{32'hA00,      0, 1, 0, 0, 1, 32'h200, 32'hA};
    tbl[17] = '{32'hA00,      0, 0, 0, 1, 1, DEF,     32'hA};
    tbl[18] = '{32'h800,      0, 0, 1, 1, 1, DEF,     32'h8};
    tbl[19] = '{32'h800,      0, 0, 1, 1, 1, DEF,     32'h0};
    tbl[20] = '{32'h0,        0, 0, 0, 1, 1, DEF,     32'h0};
    tbl[21] = '{32'h4000,     0, 0, 0, 0, 1, DEF,     32'h0};      // default request
    tbl[22] = '{32'h4000,     0, 1, 0, 0, 1, DEF,     32'h10000};  // default in service
    tbl[23] = '{32'h4000,     0, 0, 0, 1, 1, DEF,     32'h10000};
    tbl[24] = '{32'h104000,   0, 0, 0, 0, 1, 32'h600, 32'h10000};  // slot5 pre-empts default
    tbl[25] = '{32'h104000,   0, 1, 0, 0, 1, 32'h600, 32'h10020};
    tbl[26] = '{32'h104000,   0, 0, 0, 1, 1, DEF,     32'h10020};
    tbl[27] = '{32'h104000,   0, 0, 1, 1, 1, DEF,     32'h10000};
    tbl[28] = '{32'h4000,     0, 0, 1, 1, 1, DEF,     32'h0};
    tbl[29] = '{32'h4000,     0, 0, 0, 0, 1, DEF,     32'h0};
    tbl[30] = '{32'h0,        0, 0, 0, 1, 1, DEF,     32'h0};
    tbl[31] = '{32'h0,        1, 1, 0, 1, 0, DEF,     32'h0};      // FIQ; rd while idle
    tbl[32] = '{32'h0,        0, 0, 0, 1, 1, DEF,     32'h0};
    tbl[33] = '{32'h8,        1, 0, 0, 0, 0, 32'h100, 32'h0};

    // Reset values while rst is held
    repeat (2) @(negedge clk);
    chk_all("reset", 1'b1, 1'b1, 32'h0, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < NROWS; i++) begin
      IRQStatus   = tbl[i].irq;
      FIQStatus   = tbl[i].fiq;
      vectaddr_rd = tbl[i].rd;
      vectaddr_wr = tbl[i].wr;
      @(negedge clk);
      $display("row %0d irq=%h fiq=%h rd=%b wr=%b -> nirq=%b nfiq=%b addr=%h mask=%h",
               i, tbl[i].irq, tbl[i].fiq, tbl[i].rd, tbl[i].wr, nirq, nfiq, vaddr, mask);
      chk_all($sformatf("row%0d", i), tbl[i].exp_nirq, tbl[i].exp_nfiq,
              tbl[i].exp_addr, tbl[i].exp_mask);
    end

    // Reset mid-service: claim slot0 with FIQ active, then assert rst between edges
    vectaddr_rd = 1'b1;
    @(negedge clk);
    vectaddr_rd = 1'b0;
    $display("claim slot0 before reset -> nirq=%b nfiq=%b addr=%h mask=%h", nirq, nfiq, vaddr, mask);
    chk_all("preRst", 1'b0, 1'b0, 32'h100, 32'h1);
    #2 rst = 1'b1;
    #1;
    $display("async reset asserted -> nirq=%b nfiq=%b addr=%h mask=%h", nirq, nfiq, vaddr, mask);
    chk_all("asyncRst", 1'b1, 1'b1, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("after reset release -> nirq=%b nfiq=%b addr=%h mask=%h", nirq, nfiq, vaddr, mask);
    chk_all("postRst", 1'b0, 1'b0, 32'h100, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
